// File: rtl/capture_tx_sequencer.sv
// capture_tx_sequencer: buffers a burst of ADC samples, then hands them one at a time to the SPI writer.
// Ports:
//   clk, rst (async, active low)
//   start, continuous, sample_limit        burst control; limit latched and clamped on start
//   adc_valid, adc_data                    sample strobe from the ADC reader
//   tx_en, tx_data, tx_done                writer handshake; writer held in reset while tx_en low
//   busy, done, collected, transmitted     status; done pulses once per burst
//   overrun                                sticky; sample strobed outside capture in continuous mode
module capture_tx_sequencer #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [CNT_W-1:0]  sample_limit,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  collected,
  output logic [CNT_W-1:0]  transmitted,
  output logic              overrun
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, CAPTURE, LOAD, SEND, FINISH} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] limit_q, limit_d, collected_q, collected_d, transmitted_q, transmitted_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic overrun_q, overrun_d;
  logic [DATA_W-1:0] mem [DEPTH];
  // The counters double as write/read pointers: both stay below limit while indexing.
  always_ff @(posedge clk)
    if (state_q == CAPTURE && adc_valid) mem[collected_q[AW-1:0]] <= adc_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q       <= IDLE;
      limit_q       <= '0;
      collected_q   <= '0;
      transmitted_q <= '0;
      tx_data_q     <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      limit_q       <= limit_d;
      collected_q   <= collected_d;
      transmitted_q <= transmitted_d;
      tx_data_q     <= tx_data_d;
      overrun_q     <= overrun_d;
    end
  always_comb begin
    state_d       = state_q;
    limit_d       = limit_q;
    collected_d   = collected_q;
    transmitted_d = transmitted_q;
    tx_data_d     = tx_data_q;
    overrun_d     = overrun_q;
    case (state_q)
      IDLE:
        if (start) begin
          limit_d       = sample_limit == '0 ? CNT_W'(1) :
                          sample_limit > CNT_W'(DEPTH) ? CNT_W'(DEPTH) : sample_limit;
          collected_d   = '0;
          transmitted_d = '0;
          overrun_d     = 1'b0;
          state_d       = CAPTURE;
        end
      CAPTURE:
        if (adc_valid) begin
          collected_d = collected_q + CNT_W'(1);
          if (collected_d == limit_q) state_d = LOAD;
        end
      LOAD: begin
        tx_data_d = mem[transmitted_q[AW-1:0]];
        state_d   = SEND;
      end
      SEND:
        if (tx_done) begin
          transmitted_d = transmitted_q + CNT_W'(1);
          state_d       = transmitted_d == limit_q ? FINISH : LOAD;
        end
      FINISH:
        if (continuous) begin
          collected_d   = '0;
          transmitted_d = '0;
          state_d       = CAPTURE;
        end else begin
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
    if (adc_valid && continuous && (state_q == LOAD || state_q == SEND || state_q == FINISH))
      overrun_d = 1'b1;
  end
  // Handshake outputs decode straight from the state register so they never glitch.
  assign tx_en       = state_q == SEND;
  assign done        = state_q == FINISH;
  assign busy        = state_q != IDLE;
  assign tx_data     = tx_data_q;
  assign collected   = collected_q;
  assign transmitted = transmitted_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_capture_tx_sequencer.sv
// tb_capture_tx_sequencer: scoreboard bench for capture_tx_sequencer.
module tb_capture_tx_sequencer;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, continuous = 1'b0, adc_valid = 1'b0, tx_done = 1'b0;
  logic [CNT_W-1:0] sample_limit = '0;
  logic [DATA_W-1:0] adc_data = '0;
  logic tx_en, busy, done, overrun;
  logic [DATA_W-1:0] tx_data;
  logic [CNT_W-1:0] collected, transmitted;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [DATA_W-1:0] exp_q [$];
  capture_tx_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .sample_limit(sample_limit),
    .adc_valid(adc_valid), .adc_data(adc_data), .tx_en(tx_en), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .done(done), .collected(collected),
    .transmitted(transmitted), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(input logic [CNT_W-1:0] lim);
    step();
    start = 1'b1;
    sample_limit = lim;
    step();
    start = 1'b0;
  endtask
  task automatic strobe(input logic [DATA_W-1:0] d, input bit captured);
    step();
    adc_valid = 1'b1;
    adc_data = d;
    if (captured) exp_q.push_back(d);
    step();
    adc_valid = 1'b0;
  endtask
  // Writer model: waits for each enable, checks the presented sample, then answers with tx_done.
  task automatic drain(input int n);
    int t;
    logic [DATA_W-1:0] exp;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (tx_en !== 1'b1 && t < 50) begin
        step();
        t++;
      end
      exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      total_cnt++;
      if (t >= 50) $display("FAIL tx_en_wait: tx_en=%b required 1 within 50 cycles", tx_en);
      else if (tx_data !== exp) $display("FAIL tx_data[%0d]: got %h want %h", i, tx_data, exp);
      else pass_cnt++;
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      total_cnt++;
      if (tx_en !== 1'b0) $display("FAIL tx_en_after_done: got %b want 0", tx_en); else pass_cnt++;
      total_cnt++;
      if (done !== (i == n - 1)) $display("FAIL done_pulse[%0d]: got %b want %b", i, done, i == n - 1);
      else pass_cnt++;
    end
  endtask
  task automatic test_reset();
    step();
    total_cnt++;
    if ({tx_en, busy, done, overrun, collected, transmitted, tx_data} !== '0)
      $display("FAIL reset_outputs: got en=%b busy=%b done=%b ovr=%b col=%0d tx=%0d data=%h want all 0",
               tx_en, busy, done, overrun, collected, transmitted, tx_data);
    else pass_cnt++;
    rst = 1'b1;
  endtask
  task automatic test_basic();
    pulse_start(3);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else pass_cnt++;
    strobe(12'h123, 1);
    strobe(12'h456, 1);
    strobe(12'h789, 1);
    total_cnt++;
    if (collected !== 5'd3) $display("FAIL basic_collected: got %0d want 3", collected); else pass_cnt++;
    drain(3);
    total_cnt++;
    if (transmitted !== 5'd3) $display("FAIL basic_transmitted: got %0d want 3", transmitted); else pass_cnt++;
    step();
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_idle: busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
  endtask
  task automatic test_latency();
    pulse_start(2);
    strobe(12'h0a1, 1);
    strobe(12'h0b2, 1);
    total_cnt++;
    if (tx_en !== 1'b0) $display("FAIL lat_load: tx_en got %b want 0", tx_en); else pass_cnt++;
    step();
    total_cnt++;
    if (tx_en !== 1'b1 || tx_data !== 12'h0a1)
      $display("FAIL lat_first: tx_en=%b data=%h want 1 0a1", tx_en, tx_data);
    else pass_cnt++;
    void'(exp_q.pop_front());
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    total_cnt++;
    if (tx_en !== 1'b0) $display("FAIL lat_gap: tx_en got %b want 0", tx_en); else pass_cnt++;
    step();
    total_cnt++;
    if (tx_en !== 1'b1) $display("FAIL lat_reassert: tx_en got %b want 1", tx_en); else pass_cnt++;
    drain(1);
    step();
  endtask
  task automatic test_limits();
    pulse_start(0);
    strobe(12'h0aa, 1);
    drain(1);
    total_cnt++;
    if (transmitted !== 5'd1) $display("FAIL limit0_tx: got %0d want 1", transmitted); else pass_cnt++;
    step();
    pulse_start(20);
    for (int i = 0; i < 18; i++) strobe(12'(i * 7 + 1), i < DEPTH);
    total_cnt++;
    if (collected !== 5'd16 || overrun !== 1'b0)
      $display("FAIL limit20_collected: col=%0d ovr=%b want 16 0", collected, overrun);
    else pass_cnt++;
    drain(16);
    total_cnt++;
    if (transmitted !== 5'd16) $display("FAIL limit20_tx: got %0d want 16", transmitted); else pass_cnt++;
    step();
  endtask
  task automatic test_continuous();
    continuous = 1'b1;
    pulse_start(2);
    strobe(12'h311, 1);
    strobe(12'h322, 1);
    step();
    strobe(12'hfff, 0);
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL cont_overrun: got %b want 1", overrun); else pass_cnt++;
    drain(2);
    step();
    total_cnt++;
    if (busy !== 1'b1 || collected !== 5'd0)
      $display("FAIL cont_restart: busy=%b col=%0d want 1 0", busy, collected);
    else pass_cnt++;
    strobe(12'h333, 1);
    continuous = 1'b0;
    strobe(12'h344, 1);
    drain(2);
    step();
    total_cnt++;
    if (busy !== 1'b0 || overrun !== 1'b1)
      $display("FAIL cont_stop: busy=%b ovr=%b want 0 1", busy, overrun);
    else pass_cnt++;
  endtask
  task automatic test_async_reset();
    pulse_start(2);
    strobe(12'h501, 1);
    strobe(12'h502, 1);
    step();
    total_cnt++;
    if (tx_en !== 1'b1) $display("FAIL rst_pre_send: tx_en got %b want 1", tx_en); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({tx_en, busy, collected, transmitted} !== '0)
      $display("FAIL rst_async: en=%b busy=%b col=%0d tx=%0d want 0", tx_en, busy, collected, transmitted);
    else pass_cnt++;
    step();
    rst = 1'b1;
    exp_q.delete();
    pulse_start(1);
    strobe(12'h5a5, 1);
    drain(1);
    step();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_clean_burst: busy got %b want 0", busy); else pass_cnt++;
  endtask
  task automatic test_ignored();
    pulse_start(2);
    strobe(12'h611, 1);
    step();
    start = 1'b1;
    sample_limit = 5'd5;
    step();
    start = 1'b0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    total_cnt++;
    if (collected !== 5'd1 || busy !== 1'b1 || tx_en !== 1'b0 || transmitted !== 5'd0)
      $display("FAIL ign_capture: col=%0d busy=%b en=%b tx=%0d want 1 1 0 0", collected, busy, tx_en, transmitted);
    else pass_cnt++;
    strobe(12'h622, 1);
    total_cnt++;
    if (collected !== 5'd2 || tx_en !== 1'b0)
      $display("FAIL ign_limit_kept: col=%0d en=%b want 2 0", collected, tx_en);
    else pass_cnt++;
    drain(2);
    step();
    strobe(12'habc, 0);
    total_cnt++;
    if (busy !== 1'b0 || collected !== 5'd2 || overrun !== 1'b0)
      $display("FAIL ign_idle_valid: busy=%b col=%0d ovr=%b want 0 2 0", busy, collected, overrun);
    else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_limits();
    test_continuous();
    test_async_reset();
    test_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
